// File: rtl/dsp_sram_responder.sv
// dsp_sram_responder: load/store front end for a single-port synchronous SRAM.
// Stores are posted into a small FIFO write buffer and drained to the SRAM
// when it is free. Loads are forwarded from the buffer when they hit, and
// otherwise read from the SRAM with a two-cycle latency.
module dsp_sram_responder #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 15,
   parameter int WB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_stall,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_stall,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              sram_ce_n,
   output logic              sram_we_n,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = $clog2(WB_DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(WB_DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, DRAIN, DRAIN_FORCE} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
   logic [DATA_W-1:0] wb_data [WB_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_n;
   logic              push, pop, rd_accept, sram_rd, sram_wr;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;

   assign wr_stall  = (count == FULL);
   assign rd_stall  = (state == DRAIN_FORCE) || (state == RD_WAIT);
   assign rd_accept = rd_en && !rd_stall;
   assign push      = wr_en && !wr_stall;

   // Search the buffer oldest to youngest so the youngest match wins; the
   // entry being drained this cycle is still counted and so still forwards.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if ((CNT_W'(i) < count) && (wb_addr[rd_ptr + PTR_W'(i)] == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data[rd_ptr + PTR_W'(i)];
         end
      end
   end

   // Per-cycle SRAM arbitration and next state: forced drain, then read, then drain.
   always_comb begin
      sram_rd = 1'b0;
      sram_wr = 1'b0;
      case (state)
         RD_WAIT:     ;
         DRAIN_FORCE: sram_wr = 1'b1;
         default: begin
            if (rd_accept && !fwd_hit) sram_rd = 1'b1;
            else if (count != '0)      sram_wr = 1'b1;
         end
      endcase
      // No SRAM strobe may escape while reset is held.
      if (!rst_n) begin
         sram_rd = 1'b0;
         sram_wr = 1'b0;
      end
      pop     = sram_wr;
      count_n = count + CNT_W'(push) - CNT_W'(pop);
      if (sram_rd)              state_n = RD_WAIT;
      else if (count_n == FULL) state_n = DRAIN_FORCE;
      else if (count_n != '0)   state_n = DRAIN;
      else                      state_n = IDLE;
   end

   assign sram_ce_n  = !(sram_rd || sram_wr);
   assign sram_we_n  = !sram_wr;
   assign sram_addr  = sram_rd ? rd_addr : (sram_wr ? wb_addr[rd_ptr] : addr_hold);
   assign sram_wdata = sram_wr ? wb_data[rd_ptr] : wdata_hold;

   // Control state: FSM, occupancy, pointers and the held SRAM bus values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         addr_hold  <= sram_addr;
         wdata_hold <= sram_wdata;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Buffer storage; validity is tracked by count, so the contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         wb_addr[wr_ptr] <= wr_addr;
         wb_data[wr_ptr] <= wr_data;
      end
   end

   // Load return: SRAM capture after RD_WAIT or forwarded data; rd_data holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (state == RD_WAIT) begin
            rd_data  <= sram_rdata;
            rd_valid <= 1'b1;
         end else if (rd_accept && fwd_hit) begin
            rd_data  <= fwd_data;
            rd_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dsp_sram_responder.sv
// Bench for dsp_sram_responder: behavioural SRAM, reference memory and a
// queue of expected load results checked whenever rd_valid pulses.
module tb_dsp_sram_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [14:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_stall;
   logic        rd_en = 1'b0;
   logic [14:0] rd_addr = '0;
   logic        rd_stall;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        sram_ce_n, sram_we_n;
   logic [14:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mem     [0:32767];
   logic [15:0] ref_mem [0:32767];
   logic [15:0] exp_q [$];
   logic [30:0] wlog [$];

   // Values sampled at the falling edge inside step()
   logic wr_acc, rd_acc, ce_s, we_s, wr_stall_s, rd_stall_s, rdv_s;
   logic [14:0] addr_s;
   logic [15:0] wdata_s, rdd_s;

   dsp_sram_responder #(.DATA_W(16), .ADDR_W(15), .WB_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_stall(wr_stall),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_stall(rd_stall),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM model with a log of every write
   always @(posedge clk) begin
      if (!sram_ce_n) begin
         if (!sram_we_n) begin
            mem[sram_addr] <= sram_wdata;
            wlog.push_back({sram_addr, sram_wdata});
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   // Scoreboard: each rd_valid pulse consumes the oldest expected load result
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL load_result got=%h expected=none (no load outstanding)", rd_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               n_err++;
               $display("FAIL load_result got=%h expected=%h", rd_data, e);
            end
         end
      end
   end

   // One clock cycle: sample at the falling edge, record acceptance, then pass the rising edge
   task automatic step();
      @(negedge clk);
      wr_acc     = wr_en && !wr_stall;
      rd_acc     = rd_en && !rd_stall;
      ce_s       = sram_ce_n;
      we_s       = sram_we_n;
      addr_s     = sram_addr;
      wdata_s    = sram_wdata;
      wr_stall_s = wr_stall;
      rd_stall_s = rd_stall;
      rdv_s      = rd_valid;
      rdd_s      = rd_data;
      if (rd_acc) exp_q.push_back(ref_mem[rd_addr]);
      if (wr_acc) ref_mem[wr_addr] = wr_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp += 8;
      if (sram_ce_n !== 1'b1)    begin n_err++; $display("FAIL rst_ce_n got=%b expected=1", sram_ce_n); end
      if (sram_we_n !== 1'b1)    begin n_err++; $display("FAIL rst_we_n got=%b expected=1", sram_we_n); end
      if (sram_addr !== 15'h0)   begin n_err++; $display("FAIL rst_addr got=%h expected=0", sram_addr); end
      if (sram_wdata !== 16'h0)  begin n_err++; $display("FAIL rst_wdata got=%h expected=0", sram_wdata); end
      if (rd_valid !== 1'b0)     begin n_err++; $display("FAIL rst_rd_valid got=%b expected=0", rd_valid); end
      if (rd_data !== 16'h0)     begin n_err++; $display("FAIL rst_rd_data got=%h expected=0", rd_data); end
      if (wr_stall !== 1'b0)     begin n_err++; $display("FAIL rst_wr_stall got=%b expected=0", wr_stall); end
      if (rd_stall !== 1'b0)     begin n_err++; $display("FAIL rst_rd_stall got=%b expected=0", rd_stall); end
      rst_n = 1'b1;
   endtask

   task automatic test_store_load();
      wr_en = 1'b1; wr_addr = 15'h0010; wr_data = 16'h1234;
      step();
      wr_en = 1'b0; rd_en = 1'b1; rd_addr = 15'h0010;
      step();
      n_cmp += 2;
      if (!ce_s == 1'b1 && we_s == 1'b1) begin n_err++; $display("FAIL fwd_no_read ce_n=%b we_n=%b expected no read strobe", ce_s, we_s); end
      if (rd_acc !== 1'b1) begin n_err++; $display("FAIL fwd_accept got=%b expected=1", rd_acc); end
      rd_en = 1'b0;
      step();
      n_cmp += 2;
      if (rdv_s !== 1'b1)    begin n_err++; $display("FAIL fwd_valid got=%b expected=1", rdv_s); end
      if (rdd_s !== 16'h1234) begin n_err++; $display("FAIL fwd_data got=%h expected=1234", rdd_s); end
      idle(6);
   endtask

   task automatic test_sram_read();
      rd_en = 1'b1; rd_addr = 15'h7FFF;
      step();
      n_cmp += 3;
      if (ce_s !== 1'b0)      begin n_err++; $display("FAIL rd_strobe_ce got=%b expected=0", ce_s); end
      if (we_s !== 1'b1)      begin n_err++; $display("FAIL rd_strobe_we got=%b expected=1", we_s); end
      if (addr_s !== 15'h7FFF) begin n_err++; $display("FAIL rd_strobe_addr got=%h expected=7fff", addr_s); end
      rd_en = 1'b0;
      step();
      n_cmp += 2;
      if (rdv_s !== 1'b0)      begin n_err++; $display("FAIL rd_cycle1_valid got=%b expected=0", rdv_s); end
      if (rd_stall_s !== 1'b1) begin n_err++; $display("FAIL rd_wait_stall got=%b expected=1", rd_stall_s); end
      step();
      n_cmp += 2;
      if (rdv_s !== 1'b1)     begin n_err++; $display("FAIL rd_cycle2_valid got=%b expected=1", rdv_s); end
      if (rdd_s !== 16'hBEEF) begin n_err++; $display("FAIL rd_cycle2_data got=%h expected=beef", rdd_s); end
      step();
      n_cmp += 2;
      if (rdv_s !== 1'b0)     begin n_err++; $display("FAIL rd_pulse_width got=%b expected=0", rdv_s); end
      if (rdd_s !== 16'hBEEF) begin n_err++; $display("FAIL rd_data_hold got=%h expected=beef", rdd_s); end
   endtask

   task automatic test_hazard();
      wr_en = 1'b1; wr_addr = 15'h0004; wr_data = 16'h1111;
      step();
      wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 15'h0004;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      step();
      n_cmp += 2;
      if (rdv_s !== 1'b1)     begin n_err++; $display("FAIL hazard_valid got=%b expected=1", rdv_s); end
      if (rdd_s !== 16'h1111) begin n_err++; $display("FAIL hazard_old_value got=%h expected=1111", rdd_s); end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      idle(6);
      n_cmp++;
      if (rdd_s !== 16'h2222) begin n_err++; $display("FAIL hazard_new_value got=%h expected=2222", rdd_s); end
   endtask

   task automatic test_full();
      int stall_idx, stall_cycles;
      logic force_seen;
      stall_idx = -1; stall_cycles = 0; force_seen = 1'b0;
      rd_en = 1'b1; rd_addr = 15'h0100;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_addr = 15'h0020 + 15'(i); wr_data = 16'hC000 + 16'(i);
         for (int t = 0; t < 8; t++) begin
            step();
            if (wr_acc) break;
            if (stall_idx < 0) stall_idx = i;
            stall_cycles++;
            if (rd_stall_s && !ce_s && !we_s) force_seen = 1'b1;
         end
         if (!wr_acc) begin
            n_cmp++; n_err++;
            $display("FAIL full_store_timeout store=%0d got=stalled expected=accepted", i);
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
      n_cmp += 3;
      if (stall_idx != 4)    begin n_err++; $display("FAIL full_stall_on got=%0d expected=4", stall_idx); end
      if (stall_cycles != 1) begin n_err++; $display("FAIL full_stall_cycles got=%0d expected=1", stall_cycles); end
      if (!force_seen)       begin n_err++; $display("FAIL full_drain_force got=0 expected=1"); end
      idle(10);
      for (int i = 0; i < 5; i++) begin
         rd_en = 1'b1; rd_addr = 15'h0020 + 15'(i);
         step();
         rd_en = 1'b0;
         step(); step();
      end
   endtask

   task automatic test_wrap();
      logic [30:0] e;
      wlog.delete();
      for (int i = 0; i < 12; i++) begin
         wr_en = 1'b1; wr_addr = 15'h0400 + 15'(3 * i); wr_data = 16'hA000 + 16'(i);
         step();
         wr_en = 1'b0;
         step();
      end
      idle(8);
      n_cmp++;
      if (wlog.size() != 12) begin n_err++; $display("FAIL wrap_write_count got=%0d expected=12", wlog.size()); end
      for (int i = 0; i < 12 && i < wlog.size(); i++) begin
         e = {15'h0400 + 15'(3 * i), 16'hA000 + 16'(i)};
         n_cmp++;
         if (wlog[i] !== e) begin n_err++; $display("FAIL wrap_order idx=%0d got=%h expected=%h", i, wlog[i], e); end
      end
      for (int i = 0; i < 12; i += 4) begin
         rd_en = 1'b1; rd_addr = 15'h0400 + 15'(3 * i);
         step();
         rd_en = 1'b0;
         step(); step();
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] saved [3];
      int bad;
      wlog.delete();
      for (int i = 0; i < 3; i++) saved[i] = ref_mem[15'h0300 + 15'(i)];
      rd_en = 1'b1; rd_addr = 15'h0100;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_addr = 15'h0300 + 15'(i); wr_data = 16'hD300 + 16'(i);
         step();
      end
      wr_en = 1'b0; rd_en = 1'b0;
      step();
      @(negedge clk);
      n_cmp += 2;
      if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0) begin
         n_err++; $display("FAIL mid_drain_active ce_n=%b we_n=%b expected ce_n=0 we_n=0", sram_ce_n, sram_we_n);
      end
      if (sram_addr !== 15'h0300) begin n_err++; $display("FAIL mid_drain_addr got=%h expected=0300", sram_addr); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (sram_ce_n !== 1'b1) begin n_err++; $display("FAIL mid_reset_ce_n got=%b expected=1", sram_ce_n); end
      exp_q.delete();
      for (int i = 0; i < 3; i++) ref_mem[15'h0300 + 15'(i)] = saved[i];
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_en = 1'b1; rd_addr = 15'h0300;
      step();
      n_cmp += 3;
      if (ce_s !== 1'b0 || we_s !== 1'b1) begin n_err++; $display("FAIL post_reset_read ce_n=%b we_n=%b expected ce_n=0 we_n=1", ce_s, we_s); end
      if (wr_stall_s !== 1'b0) begin n_err++; $display("FAIL post_reset_wr_stall got=%b expected=0", wr_stall_s); end
      if (rd_acc !== 1'b1)     begin n_err++; $display("FAIL post_reset_accept got=%b expected=1", rd_acc); end
      rd_en = 1'b0;
      idle(10);
      bad = 0;
      foreach (wlog[i]) if (wlog[i][30:16] >= 15'h0300 && wlog[i][30:16] <= 15'h0302) bad++;
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL discarded_writes got=%0d expected=0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem[i] = 16'h0;
         ref_mem[i] = 16'h0;
      end
      mem[15'h7FFF] = 16'hBEEF;
      ref_mem[15'h7FFF] = 16'hBEEF;
      test_reset();
      test_store_load();
      test_sram_read();
      test_hazard();
      test_full();
      test_wrap();
      test_reset_mid();
      idle(4);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL loads_outstanding got=%0d expected=0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dsp_sram_responder.md
DSP_SRAM_RESPONDER -- requirements
Module: dsp_sram_responder

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  - DATA_W, 16, data word width.
  - ADDR_W, 15, word address width.
  - WB_DEPTH, 4, posted-write buffer entries (power of two, 2..8).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  - clk, in, 1, the single clock; all state changes on its rising edge.
  - rst_n, in, 1, reset: asynchronous assertion, active-low.
  - wr_en, in, 1, store request from the memory stage.
  - wr_addr, in, ADDR_W, store address.
  - wr_data, in, DATA_W, store data.
  - wr_stall, out, 1, posted-write buffer full; store not accepted.
  - rd_en, in, 1, load request.
  - rd_addr, in, ADDR_W, load address.
  - rd_stall, out, 1, load not accepted this cycle.
  - rd_data, out, DATA_W, load result.
  - rd_valid, out, 1, rd_data valid; one-cycle pulse.
  - sram_ce_n, out, 1, SRAM chip enable.
  - sram_we_n, out, 1, SRAM write enable.
  - sram_addr, out, ADDR_W, SRAM address.
  - sram_wdata, out, DATA_W, SRAM write data.
  - sram_rdata, in, DATA_W, SRAM read data, valid the cycle after a read strobe.

Function
REQ-003 A store SHALL be accepted on a rising edge with wr_en=1 and wr_stall=0; it is appended to the FIFO-ordered posted-write buffer.
REQ-004 wr_stall SHALL equal (count==WB_DEPTH), combinational from registered count; a store presented while wr_stall=1 SHALL be ignored, and the requester SHALL hold it.
REQ-005 A load SHALL be accepted when rd_en=1 and rd_stall=0; rd_stall SHALL be 1 only while state is DRAIN_FORCE or RD_WAIT.
REQ-006 Forwarding: an accepted load whose address matches any valid buffer entry SHALL return the youngest matching entry's data, with no SRAM access; rd_valid=1 on the next cycle.
REQ-007 A load and a store presented in the same cycle to the same address SHALL return the value prior to that store (buffer/SRAM content before the edge).
REQ-008 A non-forwarded load SHALL issue an SRAM read (ce_n=0, we_n=1, addr=rd_addr) in the acceptance cycle; it SHALL capture sram_rdata the next cycle and present it with rd_valid=1 on the following cycle (latency 2).
REQ-009 FSM states: IDLE, RD_WAIT, DRAIN, DRAIN_FORCE.
  - IDLE: no SRAM-side activity; this state is entered after reset.
  - RD_WAIT: one cycle capturing sram_rdata; the next state is DRAIN if count>0, else IDLE.
  - DRAIN: one SRAM write of the oldest entry (ce_n=0, we_n=0); the entry is popped at the end of the cycle.
  - DRAIN_FORCE: identical to DRAIN but blocks loads.
REQ-010 Arbitration per cycle, in priority order:
  - count==WB_DEPTH -> DRAIN_FORCE.
  - An accepted non-forwarded load -> SRAM read, then RD_WAIT.
  - count>0 -> DRAIN.
  - Otherwise -> IDLE.
REQ-011 A simultaneous push and pop SHALL leave count unchanged; buffer pointers SHALL wrap modulo WB_DEPTH; count width SHALL be clog2(WB_DEPTH)+1.
REQ-012 When no SRAM access occurs: sram_ce_n=1, sram_we_n=1, sram_addr and sram_wdata hold their last values.
REQ-013 Forwarded loads SHALL NOT block draining in the same cycle; the popped entry SHALL still be visible to forwarding in that cycle.
REQ-014 rd_data SHALL hold its value between rd_valid pulses.

Reset
REQ-015 While rst_n=0, the following SHALL apply:
  - state=IDLE; count=0; all buffer entries invalid.
  - rd_valid=0, rd_data=0.
  - sram_ce_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0.
  - wr_stall=0, rd_stall=0.
REQ-016 Reset mid-operation SHALL discard buffered stores and any pending load without issuing further SRAM accesses; the first request after deassertion SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-017 Store then load: store 0x1234 at 0x0010, load 0x0010 next cycle -> forwarded 0x1234, rd_valid one cycle later, no SRAM read strobe.
REQ-018 Full buffer: 5 back-to-back stores with WB_DEPTH=4 and loads held high -> wr_stall=1 on the 5th; DRAIN_FORCE occurs with rd_stall=1; the 5th store is accepted the cycle after the pop.
REQ-019 SRAM read: SRAM preloaded with 0xBEEF at 0x7FFF, empty buffer, load 0x7FFF -> SRAM strobe in cycle 0, rd_data=0xBEEF with rd_valid in cycle 2.
REQ-020 Same-cycle hazard: buffer holds 0x1111 at 0x0004; store 0x2222 and load 0x0004 in the same cycle -> rd_data=0x1111; a later load returns 0x2222.
REQ-021 Wrap and order: 12 stores to distinct addresses with idle gaps -> the SRAM write order equals the store order, and pointers wrap 3 times with no loss.
REQ-022 Reset mid-drain: assert rst_n=0 with count=3 -> ce_n=1 immediately; after release, count=0 and no writes to those addresses occur.
